// File: rtl/ctrl_uart_wide.sv
// rtl/ctrl_uart_wide.sv - UART-driven Wishbone B4 classic master with wide address/data
// Frames: 'W' adr.. dat.. / 'R' adr..; replies 'K' [+ read data] or 'T' on bus timeout.
module ctrl_uart_wide #(
    parameter int ADR_W       = 16,
    parameter int DAT_W       = 32,
    parameter int CLK_PER_BIT = 104,
    parameter int TIMEOUT     = 1024,
    parameter int RX_IDLE     = 65536
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    output logic               wb_cyc_o,
    output logic               wb_stb_o,
    output logic               wb_we_o,
    output logic [ADR_W-1:0]   wb_adr_o,
    output logic [DAT_W-1:0]   wb_dat_o,
    output logic [DAT_W/8-1:0] wb_sel_o,
    input  logic [DAT_W-1:0]   wb_dat_i,
    input  logic               wb_ack_i,
    input  logic               uart_rx_ni,
    output logic               uart_tx_no,
    output logic               busy_o
);

    localparam int ADR_B = (ADR_W + 7) / 8;
    localparam int DAT_B = DAT_W / 8;
    localparam int AS_W  = ADR_B * 8;
    localparam int RB_W  = (DAT_B + 1) * 8;
    localparam int CW    = $clog2(CLK_PER_BIT + 1);
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam int IW    = $clog2(RX_IDLE + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(RX_IDLE - 1);
    localparam logic [2:0]    ADR_B_C   = 3'(ADR_B);
    localparam logic [2:0]    DAT_B_C   = 3'(DAT_B);
    localparam logic [2:0]    RSP_RD_C  = 3'(DAT_B + 1);

    localparam logic [7:0] CMD_WR = 8'h57;
    localparam logic [7:0] CMD_RD = 8'h52;
    localparam logic [7:0] ST_ACK = 8'h4B;
    localparam logic [7:0] ST_TO  = 8'h54;

    typedef enum logic [1:0] {RX_IDLE_S, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [2:0] {P_IDLE, P_ADR, P_DAT, P_BUS, P_RSP} p_state_e;

    // ---------------- UART receiver ----------------
    rx_state_e       rx_state_q;
    logic            rx_meta_q, rx_s_q, rx_prev_q;
    logic [CW-1:0]   rx_cnt_q;
    logic [2:0]      rx_bit_q;
    logic [7:0]      rx_sh_q;
    logic            rx_valid_q, rx_ferr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE_S;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_meta_q  <= uart_rx_ni;
            rx_s_q     <= rx_meta_q;
            rx_prev_q  <= rx_s_q;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            case (rx_state_q)
                RX_IDLE_S: begin
                    rx_cnt_q <= '0;
                    if (rx_prev_q && !rx_s_q) rx_state_q <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        // A start bit that is high again by mid-bit was a glitch.
                        rx_state_q <= rx_s_q ? RX_IDLE_S : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q <= '0;
                        rx_sh_q  <= {rx_s_q, rx_sh_q[7:1]};
                        rx_bit_q <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_IDLE_S;
                        rx_valid_q <= rx_s_q;
                        rx_ferr_q  <= !rx_s_q;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                default: rx_state_q <= RX_IDLE_S;
            endcase
        end
    end

    // ---------------- Command parser / bus engine ----------------
    p_state_e        p_state_q;
    logic            we_q, cyc_q, busy_q;
    logic [2:0]      bcnt_q;
    logic [IW-1:0]   idle_cnt_q;
    logic [TW-1:0]   to_cnt_q;
    logic [AS_W-1:0] adr_sh_q;
    logic [DAT_W-1:0] dat_q;
    logic [RB_W-1:0] rsp_buf_q;
    logic [2:0]      rsp_cnt_q;

    logic            tx_act_q, tx_q;
    logic [CW-1:0]   tx_cnt_q;
    logic [3:0]      tx_bit_q;
    logic [8:0]      tx_sh_q;
    logic            tx_last, tx_load;

    // tx_last is the final clock of a stop bit; loading then keeps bytes gap-free.
    assign tx_last = tx_act_q && (tx_bit_q == 4'd9) && (tx_cnt_q == BIT_LAST);
    assign tx_load = (p_state_q == P_RSP) && (rsp_cnt_q != 3'd0) && (!tx_act_q || tx_last);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p_state_q  <= P_IDLE;
            we_q       <= 1'b0;
            cyc_q      <= 1'b0;
            busy_q     <= 1'b0;
            bcnt_q     <= '0;
            idle_cnt_q <= '0;
            to_cnt_q   <= '0;
            adr_sh_q   <= '0;
            dat_q      <= '0;
            rsp_buf_q  <= '0;
            rsp_cnt_q  <= '0;
        end else begin
            case (p_state_q)
                P_IDLE: begin
                    if (rx_valid_q && (rx_sh_q == CMD_WR || rx_sh_q == CMD_RD)) begin
                        we_q       <= (rx_sh_q == CMD_WR);
                        busy_q     <= 1'b1;
                        bcnt_q     <= ADR_B_C;
                        idle_cnt_q <= '0;
                        p_state_q  <= P_ADR;
                    end
                end
                P_ADR, P_DAT: begin
                    if (rx_ferr_q || (!rx_valid_q && idle_cnt_q == IDLE_LAST)) begin
                        busy_q    <= 1'b0;
                        p_state_q <= P_IDLE;
                    end else if (rx_valid_q) begin
                        idle_cnt_q <= '0;
                        if (p_state_q == P_ADR)
                            adr_sh_q <= (adr_sh_q << 8) | AS_W'(rx_sh_q);
                        else
                            dat_q <= (dat_q << 8) | DAT_W'(rx_sh_q);
                        if (bcnt_q != 3'd1) begin
                            bcnt_q <= bcnt_q - 3'd1;
                        end else if (p_state_q == P_ADR && we_q) begin
                            bcnt_q    <= DAT_B_C;
                            p_state_q <= P_DAT;
                        end else begin
                            cyc_q     <= 1'b1;
                            to_cnt_q  <= '0;
                            p_state_q <= P_BUS;
                        end
                    end else begin
                        idle_cnt_q <= idle_cnt_q + IW'(1);
                    end
                end
                P_BUS: begin
                    // Ack wins over a timeout expiring on the same edge.
                    if (wb_ack_i) begin
                        cyc_q     <= 1'b0;
                        rsp_buf_q <= {ST_ACK, wb_dat_i};
                        rsp_cnt_q <= we_q ? 3'd1 : RSP_RD_C;
                        p_state_q <= P_RSP;
                    end else if (to_cnt_q == TO_LAST) begin
                        cyc_q     <= 1'b0;
                        rsp_buf_q <= {ST_TO, {DAT_W{1'b0}}};
                        rsp_cnt_q <= 3'd1;
                        p_state_q <= P_RSP;
                    end else begin
                        to_cnt_q <= to_cnt_q + TW'(1);
                    end
                end
                P_RSP: begin
                    if (tx_load) begin
                        rsp_buf_q <= rsp_buf_q << 8;
                        rsp_cnt_q <= rsp_cnt_q - 3'd1;
                    end else if (tx_last && rsp_cnt_q == 3'd0) begin
                        busy_q    <= 1'b0;
                        p_state_q <= P_IDLE;
                    end
                end
                default: p_state_q <= P_IDLE;
            endcase
        end
    end

    // ---------------- UART transmitter (8N1) ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_q     <= 1'b1;
            tx_act_q <= 1'b0;
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            tx_sh_q  <= '1;
        end else if (tx_load) begin
            tx_q     <= 1'b0;
            tx_sh_q  <= {1'b1, rsp_buf_q[RB_W-1 -: 8]};
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            tx_act_q <= 1'b1;
        end else if (tx_act_q) begin
            if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_q <= '0;
                if (tx_bit_q == 4'd9) begin
                    tx_act_q <= 1'b0;
                end else begin
                    tx_q     <= tx_sh_q[0];
                    tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
                    tx_bit_q <= tx_bit_q + 4'd1;
                end
            end else begin
                tx_cnt_q <= tx_cnt_q + CW'(1);
            end
        end
    end

    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = cyc_q;
    assign wb_we_o    = we_q & cyc_q;
    assign wb_sel_o   = {DAT_B{cyc_q}};
    assign wb_adr_o   = adr_sh_q[ADR_W-1:0];
    assign wb_dat_o   = dat_q;
    assign uart_tx_no = tx_q;
    assign busy_o     = busy_q;

endmodule

// File: doc/ctrl_uart_wide.md
Name: ctrl_uart_wide

Overview:
- Wishbone B4 classic controller driven by a host MCU over UART, with configurable address and data widths.
- Fully self-contained: its own UART receiver and transmitter, a multi-byte command parser, a bus cycle engine with timeout, and a multi-byte response serialiser.
- Intended as the single debug/config master at the top of designs whose peripherals need more than 4-bit address / 8-bit data.

Parameters:
- ADR_W, 16: Wishbone address width, 1..32; ADR_B = ceil(ADR_W/8) address bytes on the wire.
- DAT_W, 32: Wishbone data width, multiple of 8, 8..32; DAT_B = DAT_W/8 data bytes on the wire.
- CLK_PER_BIT, 104: clock cycles per UART bit, >= 4.
- TIMEOUT, 1024: maximum bus cycle length in clocks before abort, >= 2.
- RX_IDLE, 65536: clocks without a byte before a partial frame is discarded.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  strobe
- wb_we_o  out  1  write enable
- wb_adr_o  out  ADR_W  address
- wb_dat_o  out  DAT_W  write data
- wb_sel_o  out  DAT_W/8  byte select, all ones during a cycle
- wb_dat_i  in  DAT_W  read data
- wb_ack_i  in  1  acknowledge
- uart_rx_ni  in  1  serial in, idle high
- uart_tx_no  out  1  serial out, idle high
- busy_o  out  1  high from first command byte accepted until last response stop bit sent

Behaviour:
- Reset: one clock domain, asynchronous active-low reset.
  - All outputs go to their reset values immediately: uart_tx_no=1; wb_cyc_o, wb_stb_o, wb_we_o, busy_o=0; wb_adr_o, wb_dat_o, wb_sel_o=0.
  - Parser returns to IDLE.
  - Reset mid-bus-cycle or mid-byte simply abandons the transaction.
- RX:
  - uart_rx_ni passes through a 2-flop synchroniser.
  - A falling edge in idle starts a frame; the start bit is re-checked at CLK_PER_BIT/2. If high, it is a glitch: ignore it and return to idle.
  - Data is sampled every CLK_PER_BIT, LSB first.
  - Stop bit sampled 0: framing error; the byte is dropped and the parser is forced to IDLE.
- TX: 8N1, LSB first, each bit exactly CLK_PER_BIT clocks. Response bytes are sent back-to-back with no gap.
- Protocol: all multi-byte fields are MSB first.
  - Write: 0x57 ('W'), ADR_B address bytes, DAT_B data bytes.
  - Read: 0x52 ('R'), ADR_B address bytes.
  - Any other command byte in IDLE is silently ignored: no bus cycle, no reply.
  - Address bits above ADR_W in the first address byte are discarded.
- FSM: IDLE -> ADR -> (DAT if write) -> BUS -> RSP -> IDLE.
  - ADR counts ADR_B bytes; DAT counts DAT_B bytes.
  - Bytes arriving in BUS or RSP are dropped (no RX buffering).
  - In ADR/DAT, a gap of RX_IDLE clocks since the last byte returns the FSM to IDLE.
- BUS:
  - wb_cyc_o, wb_stb_o and wb_sel_o assert on the clock after the final byte's stop-bit sample.
  - wb_adr_o and wb_dat_o are stable for the whole cycle.
  - wb_we_o=1 for write, 0 for read.
  - Cycle ends when wb_ack_i is sampled high. wb_dat_i is latched on that same edge, and cyc/stb/sel drop on the next cycle, so a single-cycle strobe is possible when ack is combinational.
  - If there is no ack after TIMEOUT clocks with stb high, stb/cyc drop and the status is timeout.
  - Ack in the same cycle the timeout expires counts as ack.
- RSP:
  - Status byte: 0x4B ('K') for ack, 0x54 ('T') for timeout.
  - Read with ack: status followed by DAT_B bytes of latched read data, MSB first.
  - Write, or any timeout: status byte only.
- busy_o: rises the cycle the command byte is accepted; falls the cycle after the last stop bit completes, or when the FSM is aborted to IDLE.

Test Plan (ADR_W=16, DAT_W=32, CLK_PER_BIT=4, TIMEOUT=16, RX_IDLE=200):
- Write: send 57 12 34 DE AD BE EF; slave acks 3 cycles after stb -> stb high exactly 3 cycles with adr=0x1234, dat=0xDEADBEEF, we=1, sel=0xF; TX emits 4B; busy_o falls after its stop bit.
- Read: send 52 00 08; slave returns 0xCAFEF00D with ack -> we=0, adr=0x0008; TX emits 4B CA FE F0 0D contiguously, each bit 4 clocks.
- Timeout: send 52 00 10 with no ack -> stb/cyc high exactly 16 cycles; TX emits 54 only; next command works normally.
- Framing error: send 57 12, then a byte with stop bit 0 -> no bus cycle, no TX, busy_o low; then a full write completes normally.
- Garbage and idle gap: send 41 -> nothing happens. Send 52 00, wait 250 clocks, send 05 -> no bus cycle.
- Reset mid-BUS: assert rst_ni low while stb is high -> cyc/stb/busy low and uart_tx_no=1 immediately, without waiting for a clock edge; after release, a read of 0x0001 succeeds.
